// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and deadband state encoding for the PWM block
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 11;
  localparam int unsigned PWM_NCH   = 2;
  localparam int unsigned PWM_DT_W  = 6;

  typedef enum logic [2:0] {
    DB_OFF      = 3'd0,
    DB_LO_ON    = 3'd1,
    DB_DT_TO_HI = 3'd2,
    DB_HI_ON    = 3'd3,
    DB_DT_TO_LO = 3'd4
  } db_state_e;

endpackage

// File: rtl/pwm_dt_chan.sv
// rtl/pwm_dt_chan.sv - one deadband channel: raw PWM in, non-overlapping hi/lo drive out
module pwm_dt_chan
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W = PWM_DT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            raw_i,
  input  logic [DT_W-1:0] dt_i,
  output logic            hi_o,
  output logic            lo_o
);

  db_state_e       state_q;
  logic [DT_W-1:0] ctr_q;
  logic            hi_q;
  logic            lo_q;
  logic            dt_zero;
  logic [DT_W-1:0] dt_load;

  // The counter is checked on the edge after loading, so it starts at dt-1;
  // a zero dead time skips the gap state so the outputs stay complementary.
  assign dt_zero = (dt_i == '0);
  assign dt_load = dt_i - DT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DB_OFF;
      ctr_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else if (!en_i) begin
      state_q <= DB_OFF;
      ctr_q   <= '0;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      unique case (state_q)
        DB_OFF: begin
          if (raw_i) begin
            if (dt_zero) begin
              state_q <= DB_HI_ON;
              hi_q    <= 1'b1;
            end else begin
              state_q <= DB_DT_TO_HI;
              ctr_q   <= dt_load;
            end
          end else begin
            if (dt_zero) begin
              state_q <= DB_LO_ON;
              lo_q    <= 1'b1;
            end else begin
              state_q <= DB_DT_TO_LO;
              ctr_q   <= dt_load;
            end
          end
        end
        DB_LO_ON: begin
          if (raw_i) begin
            lo_q <= 1'b0;
            if (dt_zero) begin
              state_q <= DB_HI_ON;
              hi_q    <= 1'b1;
            end else begin
              state_q <= DB_DT_TO_HI;
              ctr_q   <= dt_load;
            end
          end
        end
        DB_DT_TO_HI: begin
          if (!raw_i) begin
            state_q <= DB_LO_ON;
            lo_q    <= 1'b1;
          end else if (ctr_q == '0) begin
            state_q <= DB_HI_ON;
            hi_q    <= 1'b1;
          end else begin
            ctr_q <= ctr_q - DT_W'(1);
          end
        end
        DB_HI_ON: begin
          if (!raw_i) begin
            hi_q <= 1'b0;
            if (dt_zero) begin
              state_q <= DB_LO_ON;
              lo_q    <= 1'b1;
            end else begin
              state_q <= DB_DT_TO_LO;
              ctr_q   <= dt_load;
            end
          end
        end
        DB_DT_TO_LO: begin
          if (raw_i) begin
            state_q <= DB_HI_ON;
            hi_q    <= 1'b1;
          end else if (ctr_q == '0) begin
            state_q <= DB_LO_ON;
            lo_q    <= 1'b1;
          end else begin
            ctr_q <= ctr_q - DT_W'(1);
          end
        end
        default: begin
          state_q <= DB_OFF;
          hi_q    <= 1'b0;
          lo_q    <= 1'b0;
        end
      endcase
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/pwm_deadband.sv
// rtl/pwm_deadband.sv - multi-channel PWM with shared counter, period shadows and deadband
module pwm_deadband
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH,
  parameter int unsigned NCH   = PWM_NCH,
  parameter int unsigned DT_W  = PWM_DT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic [DT_W-1:0]      dead_time,
  output logic [NCH-1:0]       pwm_hi,
  output logic [NCH-1:0]       pwm_lo,
  output logic                 period_wrap
);

  logic [WIDTH-1:0]     cnt_q;
  logic [WIDTH-1:0]     cnt_d;
  logic [NCH*WIDTH-1:0] duty_act_q;
  logic [DT_W-1:0]      dt_act_q;
  logic [NCH-1:0]       raw_q;
  logic [NCH-1:0]       raw_d;
  logic                 cnt_max;
  logic                 shadow_ld;

  assign cnt_max   = (cnt_q == '1);
  // Shadows track the inputs while idle so a fresh run starts on current values.
  assign shadow_ld = !en || cnt_max;

  always_comb begin
    cnt_d = en ? cnt_q + WIDTH'(1) : '0;
    raw_d = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      raw_d[i] = (cnt_q < duty_act_q[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      duty_act_q <= '0;
      dt_act_q   <= '0;
      raw_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      raw_q <= raw_d;
      if (shadow_ld) begin
        duty_act_q <= duty;
        dt_act_q   <= dead_time;
      end
    end
  end

  assign period_wrap = en && cnt_max;

  for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
    pwm_dt_chan #(
      .DT_W (DT_W)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (en),
      .raw_i (raw_q[g]),
      .dt_i  (dt_act_q),
      .hi_o  (pwm_hi[g]),
      .lo_o  (pwm_lo[g])
    );
  end

endmodule

// File: tb/tb_pwm_deadband.sv
// tb/tb_pwm_deadband.sv - self-checking bench for pwm_deadband against a window-rule reference model
module tb_pwm_deadband;

  localparam int W    = 11;
  localparam int NCH  = 2;
  localparam int DTW  = 6;
  localparam int MAXC = (1 << W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic [NCH*W-1:0]   duty = '0;
  logic [DTW-1:0]     dead_time = '0;
  logic [NCH-1:0]     pwm_hi;
  logic [NCH-1:0]     pwm_lo;
  logic               period_wrap;

  always #5 clk = ~clk;

  pwm_deadband #(
    .WIDTH (W),
    .NCH   (NCH),
    .DT_W  (DTW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .duty        (duty),
    .dead_time   (dead_time),
    .pwm_hi      (pwm_hi),
    .pwm_lo      (pwm_lo),
    .period_wrap (period_wrap)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: counter position, per-period duty/dead-time, raw history,
  // and the side that last actually drove (a side may return without dead time).
  int  m_cnt;
  int  m_duty_act[NCH];
  int  m_dt_act;
  bit  raw_ring[NCH][256];
  int  t = 0;
  bit  running;
  int  s_edge;
  int  run_dt;
  bit  committed[NCH];
  logic [NCH-1:0] exp_hi;
  logic [NCH-1:0] exp_lo;
  logic           exp_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0d", tag, obs, expv, t);
    end
  endtask

  function automatic bit raw_at(input int ch, input int e);
    return raw_ring[ch][e & 255];
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    m_dt_act = 0;
    running = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      m_duty_act[ch] = 0;
      committed[ch] = 1'b0;
      for (int k = 0; k < 256; k++) raw_ring[ch][k] = 1'b0;
    end
  endtask

  task automatic set_duty(input int ch, input int val);
    logic [W-1:0] v;
    v = val[W-1:0];
    duty[ch*W +: W] = v;
  endtask

  task automatic tick();
    int c;
    int dt_pre;
    bit nr[NCH];
    bit win1, win0, r, h, l, b;
    c = m_cnt;
    dt_pre = m_dt_act;
    for (int ch = 0; ch < NCH; ch++) nr[ch] = (c < m_duty_act[ch]);
    if (!en || c == MAXC) begin
      for (int ch = 0; ch < NCH; ch++) m_duty_act[ch] = int'(duty[ch*W +: W]);
      m_dt_act = int'(dead_time);
    end
    m_cnt = en ? (c + 1) % (MAXC + 1) : 0;
    t++;
    for (int ch = 0; ch < NCH; ch++) raw_ring[ch][t & 255] = nr[ch];
    if (!en) begin
      running = 1'b0;
    end else if (!running) begin
      running = 1'b1;
      s_edge = t;
      run_dt = dt_pre;
      for (int ch = 0; ch < NCH; ch++) committed[ch] = !raw_at(ch, t - 1);
    end
    exp_hi = '0;
    exp_lo = '0;
    if (en) begin
      for (int ch = 0; ch < NCH; ch++) begin
        win1 = (t >= s_edge + run_dt);
        win0 = win1;
        for (int k = 0; k <= run_dt; k++) begin
          b = raw_at(ch, t - 1 - k);
          if (!b) win1 = 1'b0;
          if (b)  win0 = 1'b0;
        end
        r = raw_at(ch, t - 1);
        h = r && (committed[ch] || win1);
        l = !r && (!committed[ch] || win0);
        if (h) committed[ch] = 1'b1;
        if (l) committed[ch] = 1'b0;
        exp_hi[ch] = h;
        exp_lo[ch] = l;
      end
    end
    exp_wrap = en && (m_cnt == MAXC);
    @(posedge clk);
    @(negedge clk);
    chk("pwm_hi", pwm_hi, exp_hi);
    chk("pwm_lo", pwm_lo, exp_lo);
    chk("period_wrap", period_wrap, exp_wrap);
    chk("overlap", pwm_hi & pwm_lo, 0);
  endtask

  task automatic align();
    for (int k = 0; k < 4200 && m_cnt != MAXC; k++) tick();
    chk("align_wrap", period_wrap, 1);
  endtask

  task automatic count_period(input int ch, input int chg_at, input int chg_val,
                              output int hi_n, output int lo_n, output int gap_n, output int wr_n);
    hi_n = 0; lo_n = 0; gap_n = 0; wr_n = 0;
    for (int k = 0; k < MAXC + 1; k++) begin
      tick();
      hi_n += int'(pwm_hi[ch]);
      lo_n += int'(pwm_lo[ch]);
      gap_n += int'(!pwm_hi[ch] && !pwm_lo[ch]);
      wr_n += int'(period_wrap);
      if (m_cnt == chg_at) set_duty(0, chg_val);
    end
  endtask

  task automatic restart(input int dt);
    en = 1'b0;
    dead_time = dt[DTW-1:0];
    tick();
    tick();
    en = 1'b1;
  endtask

  function automatic int pick_duty();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return MAXC;
      2: return int'($urandom_range(1, 25));
      default: return int'($urandom_range(0, MAXC));
    endcase
  endfunction

  initial begin
    int hn, ln, gn, wn, rise;
    model_clear();

    repeat (4) begin
      @(negedge clk);
      chk("reset_hi", pwm_hi, 0);
      chk("reset_lo", pwm_lo, 0);
      chk("reset_wrap", period_wrap, 0);
    end
    rst_n = 1'b1;
    model_clear();
    repeat (5) tick();

    set_duty(0, 512);
    set_duty(1, 1024);
    restart(0);
    align();
    count_period(0, -1, 0, hn, ln, gn, wn);
    chk("d512_hi", hn, 512);
    chk("d512_lo", ln, 1536);
    chk("d512_gap", gn, 0);
    chk("d512_wraps", wn, 1);

    restart(8);
    align();
    count_period(1, -1, 0, hn, ln, gn, wn);
    chk("d1024_dt8_hi", hn, 1016);
    chk("d1024_dt8_lo", ln, 1016);
    chk("d1024_dt8_gap", gn, 16);

    set_duty(0, 256);
    restart(0);
    align();
    count_period(0, 100, 1500, hn, ln, gn, wn);
    chk("shadow_cur_hi", hn, 256);
    count_period(0, -1, 0, hn, ln, gn, wn);
    chk("shadow_next_hi", hn, 1500);

    set_duty(0, 4);
    restart(8);
    align();
    count_period(0, -1, 0, hn, ln, gn, wn);
    chk("short_pulse_hi", hn, 0);
    chk("short_pulse_lo", ln, 2044);

    for (int k = 0; k < 4200 && m_cnt != 700; k++) tick();
    en = 1'b0;
    tick();
    chk("en_drop_hi", pwm_hi, 0);
    chk("en_drop_lo", pwm_lo, 0);
    set_duty(0, 0);
    tick();
    tick();
    en = 1'b1;
    rise = -1;
    for (int k = 1; k <= 40 && rise < 0; k++) begin
      tick();
      if (pwm_lo[0]) rise = k;
    end
    chk("reen_lo_rise", rise, 9);
    set_duty(0, 512);
    align();
    count_period(0, -1, 0, hn, ln, gn, wn);
    chk("reen_hi", hn, 504);
    chk("reen_lo", ln, 1528);

    repeat (300) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hi", pwm_hi, 0);
    chk("async_rst_lo", pwm_lo, 0);
    chk("async_rst_wrap", period_wrap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (400) tick();

    for (int seg = 0; seg < 6; seg++) begin
      for (int ch = 0; ch < NCH; ch++) set_duty(ch, pick_duty());
      restart(int'($urandom_range(0, 20)));
      repeat ($urandom_range(800, 3000)) begin
        tick();
        if ($urandom_range(0, 199) == 0) set_duty(int'($urandom_range(0, NCH - 1)), pick_duty());
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_deadband.md
PWM_DEADBAND -- requirements
Module: pwm_deadband

Interface
REQ-001 Parameter WIDTH, default 11: counter and duty width in bits; PWM period is 2^WIDTH clocks.
REQ-002 Parameter NCH, default 2: number of independent PWM channels sharing one counter.
REQ-003 Parameter DT_W, default 6: dead-time field width in bits.
REQ-004 clk  input  1  clock; all flops are positive-edge triggered.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  run enable; 0 forces the block idle and both sides off.
REQ-007 duty  input  NCH*WIDTH  per-channel duty; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 dead_time  input  DT_W  dead time in clocks, shared by all channels.
REQ-009 pwm_hi  output  NCH  high-side drive per channel, registered.
REQ-010 pwm_lo  output  NCH  low-side drive per channel, registered.
REQ-011 period_wrap  output  1  one-cycle pulse at each counter wrap.

Function
REQ-012 Counter cnt (WIDTH bits) SHALL increment by 1 per clock while en=1, wrap from 2^WIDTH-1 to 0, and be held at 0 while en=0.
REQ-013 period_wrap SHALL be 1 in exactly the cycles where en=1 and cnt=2^WIDTH-1.
REQ-014 Active duty and dead-time shadows SHALL load from duty/dead_time when en=0 or when cnt=2^WIDTH-1; otherwise they hold, so mid-period input changes take effect from the next period.
REQ-015 Per-channel raw_q SHALL be registered as (cnt < duty_act[i]), unsigned compare; duty=0 gives 0% and the maximum duty gives one low cycle per period.
REQ-016 Each channel SHALL run a deadband FSM with states OFF, LO_ON, DT_TO_HI, HI_ON and DT_TO_LO, plus a DT_W-bit down-counter.
REQ-017 OFF: pwm_hi=0, pwm_lo=0. When en=1 the FSM SHALL go to DT_TO_LO if raw_q=0, or to DT_TO_HI if raw_q=1, loading dt_act.
REQ-018 LO_ON (lo=1, hi=0): if raw_q=1, go to DT_TO_HI and load dt_act.
REQ-019 DT_TO_HI (both 0): go to HI_ON when the counter reaches 0; if raw_q=0 first, go directly to LO_ON.
REQ-020 HI_ON (hi=1, lo=0): if raw_q=0, go to DT_TO_LO and load dt_act.
REQ-021 DT_TO_LO (both 0): go to LO_ON when the counter reaches 0; if raw_q=1 first, go directly to HI_ON.
REQ-022 Timing: if raw_q changes at clock edge E, the active side SHALL drop at E+1 and the opposite side SHALL rise at E+1+dt_act.
REQ-023 dt_act=0 SHALL yield strictly complementary outputs with no gap.
REQ-024 A raw pulse shorter than dt_act SHALL be swallowed: the opposite side never asserts.
REQ-025 Invariant: pwm_hi[i] and pwm_lo[i] SHALL never both be 1 in any cycle, including across reset, en changes and shadow loads.
REQ-026 en falling SHALL force every channel to OFF (both outputs 0) on the next edge, regardless of state.

Reset
REQ-027 While rst_n=0: cnt=0, raw_q=0, all FSMs in OFF, pwm_hi=0, pwm_lo=0, period_wrap=0, duty_act=0, dt_act=0, dead-time counters=0.
REQ-028 Reset asserted mid-period SHALL clear all state immediately (asynchronously); after release the block behaves as after REQ-017.

Structure
REQ-029 Package pwm_pkg SHALL hold the deadband state enum and the default WIDTH/NCH/DT_W constants.
REQ-030 Sub-module pwm_dt_chan SHALL implement one channel (FSM, dead-time counter, output flops); the top SHALL instantiate it NCH times, with one shared counter and the shadow registers in the top.

Verification (WIDTH=11, NCH=2)
REQ-031 Reset held, then released with en=0 -> all outputs 0 and period_wrap=0.
REQ-032 en=1, dead_time=0, duty0=512 -> pwm_hi[0] high 512 of every 2048 clocks, pwm_lo[0] equals its inverse, and period_wrap pulses every 2048 clocks.
REQ-033 dead_time=8, duty1=1024 -> pwm_hi[1] high 1016 clocks and pwm_lo[1] high 1016 clocks per period, with two 8-clock both-low gaps; the invariant assertion never fires.
REQ-034 duty0 changed from 256 to 1500 at cnt=100 -> the current period still has a 256-clock high window; the next period has a 1500-clock window.
REQ-035 duty0=4, dead_time=8 -> pwm_hi[0] never asserts and pwm_lo[0] is low for 4 clocks per period.
REQ-036 en dropped at cnt=700 -> both outputs 0 one clock later and cnt=0; en re-raised -> pwm_lo rises after 8 clocks (dead_time=8), then normal periods resume.
